// File: rtl/imem_fetch_stage_if.sv
// Instruction-memory channel between the fetch stage (master) and the memory (slave).
// Valid/ready request with a word address, valid-only response carrying the instruction word.
interface imem_fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/imem_fetch_stage.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time, holds the
// returned word for the decoder and honours PC redirects by squashing in-flight fetches.
module imem_fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  imem_fetch_stage_if.master  imem,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [XLEN-1:0]     instr,
  output logic [6:0]          opCode,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic [XLEN-1:0]     instr_pc,
  output logic [XLEN-1:0]     pc_plus4,
  output logic                illegal,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic [XLEN-1:0]     fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_KILL,
    S_HOLD
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] instr_n, instr_pc_n, fetch_count_n;
  logic [XLEN-1:0] redirect_tgt;

  // Targets are word aligned; masking keeps every input bit in use.
  assign redirect_tgt = redirect_pc & ~(XLEN'(3));

  // NOTE: every variable gets its hold value before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    fetch_count_n = fetch_count;
    if (redirect_valid) pc_n = redirect_tgt;
    unique case (state)
      S_IDLE: state_n = S_REQ;
      S_REQ: begin
        if (imem.imem_req_ready) state_n = redirect_valid ? S_KILL : S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          state_n = S_REQ;
          if (!redirect_valid) begin
            instr_n    = imem.imem_rsp_data;
            instr_pc_n = pc;
            pc_n       = pc + XLEN'(4);
            state_n    = S_HOLD;
          end
        end else if (redirect_valid) begin
          state_n = S_KILL;
        end
      end
      S_KILL: begin
        if (imem.imem_rsp_valid) state_n = S_REQ;
      end
      S_HOLD: begin
        // A redirect with ready high is a retiring taken branch and still counts.
        if (instr_ready) fetch_count_n = fetch_count + XLEN'(1);
        if (instr_ready || redirect_valid) state_n = S_REQ;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      fetch_count <= fetch_count_n;
    end
  end

  assign imem.imem_req_valid = (state == S_REQ);
  assign imem.imem_req_addr  = pc;
  assign instr_valid         = (state == S_HOLD);
  assign opCode              = instr[6:0];
  assign funct3              = instr[14:12];
  assign funct7              = instr[31:25];
  assign pc_plus4            = instr_pc + XLEN'(4);
  assign illegal             = instr_valid &&
                               !(opCode inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011});

endmodule

// File: tb/tb_imem_fetch_stage.sv
// Directed and randomized checks of imem_fetch_stage against a transaction-level model
// (outstanding request, taint on redirect, held instruction, next fetch address).
module tb_imem_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid, instr_ready, illegal, redirect_valid;
  logic [31:0] instr, instr_pc, pc_plus4, redirect_pc, fetch_count;
  logic [6:0]  opCode, funct7;
  logic [2:0]  funct3;

  imem_fetch_stage_if #(.XLEN(32)) mif ();

  imem_fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (mif),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .opCode         (opCode),
    .funct3         (funct3),
    .funct7         (funct7),
    .instr_pc       (instr_pc),
    .pc_plus4       (pc_plus4),
    .illegal        (illegal),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          idle, outstanding, tainted, holding;
  logic [31:0] exp_pc, o_addr, h_instr, h_pc, cnt;
  int          cyc;

  // Memory model state
  logic [31:0] ovr [logic [31:0]];
  bit          m_pend;
  int          m_cnt, lat_min, lat_max, acc_count;
  logic [31:0] m_addr;

  function automatic logic [31:0] word_at(logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic bit legal_op(logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit exp_reqv();
    return !reset && !idle && !outstanding && !holding;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("req_valid", 32'(mif.imem_req_valid), 32'(exp_reqv()));
    if (exp_reqv()) check("req_addr", mif.imem_req_addr, exp_pc);
    check("instr_valid", 32'(instr_valid), 32'(holding));
    if (holding) begin
      check("instr",    instr,    h_instr);
      check("instr_pc", instr_pc, h_pc);
      check("pc_plus4", pc_plus4, h_pc + 32'd4);
      check("opCode",   32'(opCode), 32'(h_instr[6:0]));
      check("funct3",   32'(funct3), 32'(h_instr[14:12]));
      check("funct7",   32'(funct7), 32'(h_instr[31:25]));
    end
    check("illegal", 32'(illegal), 32'(holding && !legal_op(h_instr[6:0])));
    check("fetch_count", fetch_count, cnt);
  endtask

  // One clock: model and memory react to the values present before the edge.
  task automatic cycle();
    bit          acc_m, dut_acc, rsp, rd, rdy;
    logic [31:0] tgt, dut_addr;
    acc_m    = exp_reqv() && mif.imem_req_ready;
    dut_acc  = mif.imem_req_valid && mif.imem_req_ready;
    dut_addr = mif.imem_req_addr;
    rsp      = mif.imem_rsp_valid;
    rd       = redirect_valid;
    rdy      = instr_ready;
    tgt      = redirect_pc & 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    cyc++;
    if (idle) begin
      idle = 1'b0;
    end else begin
      if (holding) begin
        if (rdy) cnt = cnt + 32'd1;
        if (rdy || rd) holding = 1'b0;
      end
      if (outstanding && rsp) begin
        outstanding = 1'b0;
        if (!tainted && !rd) begin
          holding = 1'b1;
          h_instr = word_at(o_addr);
          h_pc    = o_addr;
          exp_pc  = o_addr + 32'd4;
        end
      end else if (outstanding && rd) begin
        tainted = 1'b1;
      end
      if (acc_m) begin
        outstanding = 1'b1;
        o_addr      = exp_pc;
        tainted     = rd;
      end
    end
    if (rd) exp_pc = tgt;
    mif.imem_rsp_valid = 1'b0;
    mif.imem_rsp_data  = $urandom;
    if (dut_acc) begin
      m_pend = 1'b1;
      m_addr = dut_addr;
      m_cnt  = $urandom_range(lat_max, lat_min);
      acc_count++;
    end
    if (m_pend) begin
      m_cnt--;
      if (m_cnt <= 0) begin
        mif.imem_rsp_valid = 1'b1;
        mif.imem_rsp_data  = word_at(m_addr);
        m_pend = 1'b0;
      end
    end
    redirect_valid = 1'b0;
    check_outputs();
  endtask

  // Asserted mid-cycle; a stale response is driven through reset and the IDLE cycle.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("rst_req_valid", 32'(mif.imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_fetch_count", fetch_count, 32'd0);
    idle = 1'b1; outstanding = 1'b0; tainted = 1'b0; holding = 1'b0;
    exp_pc = RESET_PC; cnt = '0; h_instr = '0; h_pc = '0; m_pend = 1'b0;
    mif.imem_rsp_valid = 1'b1;
    mif.imem_rsp_data  = 32'h0000_A003;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_req_valid", 32'(mif.imem_req_valid), 32'd0);
    check("rst_hold_instr_valid", 32'(instr_valid), 32'd0);
    reset = 1'b0;
    cyc   = 0;
    #1;
    check_outputs();
  endtask

  task automatic wait_instr(string tag);
    for (int i = 0; i < 40 && !instr_valid; i++) cycle();
    check(tag, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    int          v_cyc[$];
    bit          prev;
    int          a0;
    logic [31:0] c0;

    reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mif.imem_req_ready = 1'b1; mif.imem_rsp_valid = 1'b0; mif.imem_rsp_data = '0;
    lat_min = 1; lat_max = 1; acc_count = 0; m_cnt = 0; m_addr = '0; cyc = 0;
    ovr[32'h0] = 32'h0000_0033;
    ovr[32'h4] = 32'h0000_A003;
    apply_reset();

    // Basic streaming: valid at cycles 3 and 6, two instructions consumed.
    instr_ready = 1'b1;
    prev = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (instr_valid && !prev) v_cyc.push_back(cyc);
      prev = instr_valid;
    end
    check("first_valid_cycle", 32'(v_cyc.size() > 0 ? v_cyc[0] : -1), 32'd3);
    check("second_valid_cycle", 32'(v_cyc.size() > 1 ? v_cyc[1] : -1), 32'd6);
    check("two_consumed", fetch_count, 32'd2);

    // Stall in HOLD, then a single ready pulse.
    instr_ready = 1'b0;
    wait_instr("hold_reached");
    a0 = acc_count;
    repeat (5) cycle();
    check("stall_no_request", 32'(acc_count), 32'(a0));
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    for (int i = 0; i < 10 && acc_count == a0; i++) cycle();
    check("after_stall_addr", m_addr, h_pc + 32'd4);

    // Squash to 0x10, then a taken branch retiring to 0x40 (and 0x43 aligned down).
    wait_instr("hold_before_squash");
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    cycle();
    wait_instr("hold_at_10");
    check("instr_pc_10", instr_pc, 32'h10);
    c0 = cnt;
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    cycle();
    instr_ready = 1'b0;
    check("branch_counted", fetch_count, c0 + 32'd1);
    check("branch_addr_40", mif.imem_req_addr, 32'h40);
    wait_instr("hold_at_40");
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h43;
    cycle();
    instr_ready = 1'b0;
    check("unaligned_addr_40", mif.imem_req_addr, 32'h40);

    // Redirect while waiting on a slow response: that word is never presented.
    lat_min = 4; lat_max = 4;
    a0 = acc_count;
    for (int i = 0; i < 10 && acc_count == a0; i++) cycle();
    ovr[m_addr] = 32'hDEAD_BEEF;
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    cycle();
    a0 = acc_count;
    for (int i = 0; i < 20 && acc_count == a0; i++) cycle();
    check("wait_redirect_addr", m_addr, 32'h80);
    lat_min = 1; lat_max = 1;
    wait_instr("hold_at_80");
    check("instr_at_80", instr, word_at(32'h80));

    // Request held off for 3 cycles with a redirect in the second.
    mif.imem_req_ready = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 10 && !exp_reqv(); i++) cycle();
    instr_ready = 1'b0;
    a0 = acc_count;
    cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycle();
    cycle();
    mif.imem_req_ready = 1'b1;
    cycle();
    wait_instr("hold_at_100");
    check("single_accept", 32'(acc_count), 32'(a0 + 1));
    check("instr_pc_100", instr_pc, 32'h100);
    check("instr_at_100", instr, word_at(32'h100));

    // Unknown opcode is flagged but presented and consumed normally.
    ovr[32'h104] = 32'h0000_006F;
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    wait_instr("hold_at_104");
    check("illegal_jal", 32'(illegal), 32'd1);

    // PC wraps from the top of the address space to 0.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    wait_instr("hold_at_top");
    check("pc_plus4_wrap", pc_plus4, 32'h0);
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    check("wrap_addr", mif.imem_req_addr, 32'h0);

    // Asynchronous reset while a slow response is outstanding.
    lat_min = 4; lat_max = 4;
    a0 = acc_count;
    for (int i = 0; i < 10 && acc_count == a0; i++) cycle();
    apply_reset();
    lat_min = 1; lat_max = 3;
    repeat (8) cycle();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      mif.imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready        = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 | 32'($urandom_range(0, 7))
                                                     : $urandom;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_stage.md
Name: imem_fetch_stage

Overview:
- Fetch stage directly upstream of the single-cycle decoder (main decoder + ALU decoder).
- Owns the PC and issues one instruction-memory request at a time over a valid/ready request channel with a valid-only response channel.
- Holds the returned word and presents it with pre-sliced opCode/funct3/funct7 fields to the decoder under a valid/ready handshake.
- Accepts PC redirects (taken beq, PCSrc=1), squashing any in-flight fetch.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  XLEN  word address = current pc.
- imem_rsp_valid  input  1  response data valid; at most one per accepted request, ≥1 cycle after acceptance.
- imem_rsp_data  input  XLEN  instruction word.
- instr_valid  output  1  instruction held for the decoder.
- instr_ready  input  1  decoder/execute consumes the instruction this cycle.
- instr  output  XLEN  held instruction.
- opCode  output  7  instr[6:0].
- funct3  output  3  instr[14:12].
- funct7  output  7  instr[31:25].
- instr_pc  output  XLEN  address of the held instruction.
- pc_plus4  output  XLEN  instr_pc + 4, modulo 2^XLEN.
- illegal  output  1  instr_valid and opCode not in {0000011, 0100011, 0110011, 1100011}.
- redirect_valid  input  1  load redirect_pc as the next fetch address.
- redirect_pc  input  XLEN  redirect target; bits [1:0] ignored (forced to 0).
- fetch_count  output  XLEN  number of instructions consumed (instr_valid & instr_ready), wraps.

Behaviour:
- Reset values: state=IDLE; pc=RESET_PC; instr=0; instr_pc=0; fetch_count=0. All valid outputs are 0 while reset is asserted.
- Outputs are driven from state/registers only. No combinational path exists from instr_ready or redirect_valid to any output.
- FSM:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req_valid=1, addr=pc.
    - req_ready & !redirect → WAIT.
    - req_ready & redirect → pc=redirect_pc, KILL (the accepted request is stale).
    - !req_ready & redirect → pc=redirect_pc, stay in REQ; the address changes next cycle.
  - WAIT: no request.
    - rsp_valid & !redirect → instr=rsp_data, instr_pc=pc, pc=pc+4, HOLD.
    - rsp_valid & redirect → drop the response, pc=redirect_pc, REQ.
    - !rsp_valid & redirect → pc=redirect_pc, KILL.
  - KILL: no request. Await rsp_valid, discard it, then REQ. A further redirect while in KILL updates pc (last one wins).
  - HOLD: instr_valid=1; instr and fields are stable until consumed.
    - instr_ready & !redirect → REQ (pc already = instr_pc+4).
    - redirect (with or without instr_ready) → pc=redirect_pc, REQ. If ready was also high, the instruction counts as consumed (a branch retiring with PCSrc=1). If ready was low, the held instruction is squashed and not counted.
- Redirect has priority over sequential increment in every state.
- Fetch latency: request acceptance to instr_valid = response latency + 1 cycle (response is registered). Minimum back-to-back throughput is one instruction per 3 cycles (REQ→WAIT→HOLD).
- pc wraps from 32'hFFFF_FFFC to 0. fetch_count wraps from all-ones to 0.
- Reset asserted mid-operation (any state) returns to IDLE immediately. Any response arriving during or after reset, before the first new request, is ignored.
- imem_rsp_valid in IDLE, REQ or HOLD (protocol violation) is ignored and changes no state.
- illegal is informational only; the instruction is still presented and consumed normally.

Test Plan:
- Reset release, memory always ready, 1-cycle response, words 0x00000033,0x0000A003 → imem_req_addr 0x0 then 0x4; instr_valid at cycles 3 and 6 after release; opCode 0110011 then 0000011; fetch_count=2.
- HOLD with instr_ready=0 for 5 cycles → instr, instr_pc and pc_plus4 stable, no new request issued; ready pulse → next request at instr_pc+4.
- In HOLD at instr_pc=0x10, instr_ready=1 & redirect_valid=1, redirect_pc=0x40 → next imem_req_addr=0x40, fetch_count+1; redirect_pc=0x43 → addr 0x40.
- Redirect in WAIT to 0x80, response arrives 4 cycles later with 0xDEADBEEF → no instr_valid for that word; next request addr=0x80.
- imem_req_ready held low 3 cycles with redirect to 0x100 in cycle 2 → request addr switches to 0x100, only one request accepted, correct word presented.
- opCode 1101111 returned → illegal=1 with instr_valid; async reset asserted in WAIT → all valids 0 immediately, pc=RESET_PC, late response ignored.
